// File: rtl/nim_input_register_fifo_pkg.sv
// Register map, fill pattern and STATUS layout shared by the NIM input register FIFO.
package nim_input_register_fifo_pkg;

    typedef enum logic [2:0] {
        REG_LATCH    = 3'd0,
        REG_CTRL     = 3'd1,
        REG_STATUS   = 3'd2,
        REG_DATA_POP = 3'd3,
        REG_TAG_PEEK = 3'd4,
        REG_FLUSH    = 3'd5
    } reg_addr_e;

    localparam logic [31:0] EMPTY_PATTERN = 32'hFEFE_FEFE;

    localparam int STATUS_EMPTY_BIT = 16;
    localparam int STATUS_FULL_BIT  = 17;
    localparam int STATUS_OVF_BIT   = 18;

    function automatic logic [31:0] pack_status(input logic [15:0] count,
                                                input logic        empty,
                                                input logic        full,
                                                input logic        ovf);
        logic [31:0] word;
        word                   = 32'(count);
        word[STATUS_EMPTY_BIT] = empty;
        word[STATUS_FULL_BIT]  = full;
        word[STATUS_OVF_BIT]   = ovf;
        return word;
    endfunction

endpackage

// File: rtl/nim_input_register_fifo_fifo.sv
// Synchronous snapshot FIFO: push/pop/flush with count, full, empty and head-of-queue data.
module snapshot_fifo #(
    parameter int DATA_W     = 28,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  SYSCLK,
    input  logic                  RSTB,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  pop_ok;
    logic                  push_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (DEPTH_LOG2+1)'(DEPTH));
    assign pop_ok  = pop & ~empty & ~flush;
    // A pop or a flush in the same cycle frees room, so a push onto a full FIFO is still taken.
    assign push_ok = push & (~full | pop_ok | flush);
    assign wr_addr = flush ? '0 : wr_ptr;

    always_ff @(posedge SYSCLK) begin
        if (push_ok) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTB) begin
        if (!RSTB) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= DEPTH_LOG2'(push_ok);
            cnt    <= (DEPTH_LOG2+1)'(push_ok);
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/nim_input_register_fifo_sync.sv
// Two-flop synchroniser plus output register for asynchronous inputs (3 cycles latency).
module async_input_sync #(
    parameter int W = 1
) (
    input  logic         SYSCLK,
    input  logic         RSTB,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync_p0;
    logic [W-1:0] sync_p1;
    logic [W-1:0] sync_p2;

    always_ff @(posedge SYSCLK or negedge RSTB) begin
        if (!RSTB) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign q = sync_p2;

endmodule

// File: rtl/nim_input_register_fifo.sv
// NIM input register: N-channel hit latch (level/edge) with trigger-driven snapshot FIFO on the CPLD register bus.
module nim_input_register_fifo #(
    parameter int NCH        = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int TAGW       = 12
) (
    input  logic            SYSCLK,
    input  logic            RSTB,
    input  logic [NCH-1:0]  NIM_IN,
    input  logic            TRIG,
    input  logic [TAGW-1:0] ENC,
    input  logic            WR_STB,
    input  logic            RD_STB,
    input  logic [2:0]      ADDR,
    input  logic [31:0]     WDATA,
    output logic [31:0]     RDATA,
    output logic            RVALID,
    output logic            FIFO_NE
);

    import nim_input_register_fifo_pkg::*;

    logic [NCH-1:0]        nim_s;
    logic [NCH-1:0]        nim_d;
    logic [NCH-1:0]        set_bits;
    logic [NCH-1:0]        latch;
    logic                  trig_s;
    logic                  trig_d;
    logic                  trig_edge;
    logic [1:0]            ctrl;
    logic                  ovf;
    reg_addr_e             addr_e;
    logic                  wr_en;
    logic                  rd_en;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic [TAGW+NCH-1:0]   fifo_din;
    logic [TAGW+NCH-1:0]   fifo_head;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [31:0]           rd_word;
    logic [31:0]           rdata_p0;
    logic                  vld_p0;
    logic                  unused_wdata;

    async_input_sync #(.W(NCH)) u_nim_sync (
        .SYSCLK (SYSCLK),
        .RSTB   (RSTB),
        .d      (NIM_IN),
        .q      (nim_s)
    );

    async_input_sync #(.W(1)) u_trig_sync (
        .SYSCLK (SYSCLK),
        .RSTB   (RSTB),
        .d      (TRIG),
        .q      (trig_s)
    );

    snapshot_fifo #(
        .DATA_W     (TAGW + NCH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .SYSCLK (SYSCLK),
        .RSTB   (RSTB),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .din    (fifo_din),
        .head   (fifo_head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign addr_e       = reg_addr_e'(ADDR);
    // A write wins over a simultaneous read; the read is dropped entirely.
    assign wr_en        = WR_STB;
    assign rd_en        = RD_STB & ~WR_STB;
    assign unused_wdata = ^WDATA[31:2];

    assign set_bits  = ctrl[0] ? (nim_s & ~nim_d) : nim_s;
    assign trig_edge = trig_s & ~trig_d;
    assign fifo_din  = {ENC, latch};

    assign flush = wr_en & (addr_e == REG_FLUSH);
    assign pop   = rd_en & (addr_e == REG_DATA_POP) & ~fifo_empty;
    assign push  = trig_edge & (~fifo_full | pop | flush);

    always_comb begin
        rd_word = EMPTY_PATTERN;
        case (addr_e)
            REG_LATCH:    rd_word = 32'(latch);
            REG_CTRL:     rd_word = {30'd0, ctrl};
            REG_STATUS:   rd_word = pack_status(16'(fifo_count), fifo_empty, fifo_full, ovf);
            REG_DATA_POP: if (!fifo_empty) rd_word = 32'(fifo_head[NCH-1:0]);
            REG_TAG_PEEK: if (!fifo_empty) rd_word = 32'(fifo_head[NCH +: TAGW]);
            default:      rd_word = EMPTY_PATTERN;
        endcase
    end

    // Stage p0: latch/control update and registered read port.
    always_ff @(posedge SYSCLK or negedge RSTB) begin
        if (!RSTB) begin
            nim_d    <= '0;
            trig_d   <= 1'b0;
            latch    <= '0;
            ctrl     <= 2'b00;
            ovf      <= 1'b0;
            rdata_p0 <= '0;
            vld_p0   <= 1'b0;
        end else begin
            nim_d  <= nim_s;
            trig_d <= trig_s;

            // Bits set in this very cycle survive both auto-clear and a software clear.
            if ((trig_edge && ctrl[1]) || (wr_en && addr_e == REG_LATCH)) begin
                latch <= set_bits;
            end else begin
                latch <= latch | set_bits;
            end

            if (wr_en && addr_e == REG_CTRL) begin
                ctrl <= WDATA[1:0];
            end

            if (trig_edge && !push) begin
                ovf <= 1'b1;
            end else if (wr_en && addr_e == REG_STATUS) begin
                ovf <= 1'b0;
            end

            vld_p0 <= rd_en;
            if (rd_en) begin
                rdata_p0 <= rd_word;
            end
        end
    end

    assign RDATA   = rdata_p0;
    assign RVALID  = vld_p0;
    assign FIFO_NE = ~fifo_empty;

endmodule

// File: tb/tb_nim_input_register_fifo.sv
// Bench for nim_input_register_fifo: directed register/FIFO scenarios, then random transactions vs a queue model.
module tb_nim_input_register_fifo;

    localparam int NCH   = 16;
    localparam int DL    = 2;
    localparam int TAGW  = 12;
    localparam int DEPTH = 4;
    localparam logic [31:0] FILL = 32'hFEFE_FEFE;

    logic            SYSCLK = 1'b0;
    logic            RSTB   = 1'b0;
    logic [NCH-1:0]  NIM_IN = '0;
    logic            TRIG   = 1'b0;
    logic [TAGW-1:0] ENC    = '0;
    logic            WR_STB = 1'b0;
    logic            RD_STB = 1'b0;
    logic [2:0]      ADDR   = '0;
    logic [31:0]     WDATA  = '0;
    logic [31:0]     RDATA;
    logic            RVALID;
    logic            FIFO_NE;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level reference state
    logic [15:0] m_latch;
    logic [1:0]  m_ctrl;
    logic        m_ovf;
    logic [27:0] m_q[$];

    nim_input_register_fifo #(.NCH(NCH), .DEPTH_LOG2(DL), .TAGW(TAGW)) dut (
        .SYSCLK  (SYSCLK),
        .RSTB    (RSTB),
        .NIM_IN  (NIM_IN),
        .TRIG    (TRIG),
        .ENC     (ENC),
        .WR_STB  (WR_STB),
        .RD_STB  (RD_STB),
        .ADDR    (ADDR),
        .WDATA   (WDATA),
        .RDATA   (RDATA),
        .RVALID  (RVALID),
        .FIFO_NE (FIFO_NE)
    );

    always #15 SYSCLK = ~SYSCLK;

    initial begin
        #2500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge SYSCLK);
        ADDR   = a;
        RD_STB = 1'b1;
        @(negedge SYSCLK);
        RD_STB = 1'b0;
        check_eq("rvalid", 32'(RVALID), 32'd1);
        d = RDATA;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_rd(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge SYSCLK);
        ADDR   = a;
        WDATA  = d;
        WR_STB = 1'b1;
        @(negedge SYSCLK);
        WR_STB = 1'b0;
    endtask

    task automatic nim_pulse(input logic [15:0] p);
        @(negedge SYSCLK);
        NIM_IN = p;
        repeat (2) @(negedge SYSCLK);
        NIM_IN = '0;
        repeat (5) @(negedge SYSCLK);
    endtask

    task automatic fire(input logic [11:0] enc);
        @(negedge SYSCLK);
        ENC  = enc;
        TRIG = 1'b1;
        repeat (5) @(negedge SYSCLK);
        TRIG = 1'b0;
        repeat (5) @(negedge SYSCLK);
    endtask

    // Trigger whose edge reaches the FIFO in the same cycle as a register strobe.
    task automatic fire_with_strobe(input logic [11:0] enc, input logic is_wr,
                                    input logic [2:0] a, output logic [31:0] d);
        @(negedge SYSCLK);
        ENC  = enc;
        TRIG = 1'b1;
        repeat (3) @(negedge SYSCLK);
        ADDR   = a;
        WDATA  = '0;
        WR_STB = is_wr;
        RD_STB = ~is_wr;
        @(negedge SYSCLK);
        WR_STB = 1'b0;
        RD_STB = 1'b0;
        d = RDATA;
        if (!is_wr) check_eq("coinc_rvalid", 32'(RVALID), 32'd1);
        repeat (2) @(negedge SYSCLK);
        TRIG = 1'b0;
        repeat (5) @(negedge SYSCLK);
    endtask

    task automatic m_reset();
        m_latch = '0;
        m_ctrl  = '0;
        m_ovf   = 1'b0;
        m_q.delete();
    endtask

    task automatic m_fire(input logic [11:0] enc);
        if (m_q.size() < DEPTH) m_q.push_back({enc, m_latch});
        else m_ovf = 1'b1;
        if (m_ctrl[1]) m_latch = '0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(m_q.size());
        if (m_q.size() == 0)     s = s + 32'h0001_0000;
        if (m_q.size() == DEPTH) s = s + 32'h0002_0000;
        if (m_ovf)               s = s + 32'h0004_0000;
        return s;
    endfunction

    initial begin
        logic [31:0] d;
        logic [15:0] p;
        logic [11:0] e;
        logic [1:0]  c;
        int          op;

        // Reset with NIM_IN[0] held high from the start
        NIM_IN = 16'h0001;
        repeat (3) @(negedge SYSCLK);
        check_eq("rst_rdata", RDATA, 32'd0);
        check_eq("rst_rvalid", 32'(RVALID), 32'd0);
        check_eq("rst_fifo_ne", 32'(FIFO_NE), 32'd0);
        RSTB = 1'b1;
        repeat (5) @(negedge SYSCLK);
        rd_chk("init_status", 3'd2, 32'h0001_0000);
        rd_chk("init_ctrl", 3'd1, 32'd0);
        rd_chk("level_held", 3'd0, 32'h1);

        // Edge mode: a held input does not re-set the latch after a clear
        reg_wr(3'd1, 32'h1);
        reg_wr(3'd0, 32'h0);
        repeat (5) @(negedge SYSCLK);
        rd_chk("edge_held", 3'd0, 32'h0);
        NIM_IN = '0;
        repeat (5) @(negedge SYSCLK);
        NIM_IN = 16'h0001;
        repeat (5) @(negedge SYSCLK);
        rd_chk("edge_rise", 3'd0, 32'h1);
        NIM_IN = '0;
        reg_wr(3'd1, 32'h0);
        reg_wr(3'd0, 32'h0);

        // Level mode
        nim_pulse(16'h0008);
        rd_chk("level_pulse", 3'd0, 32'h8);
        reg_wr(3'd0, 32'hDEAD_BEEF);
        rd_chk("level_clear", 3'd0, 32'h0);

        // Single snapshot
        nim_pulse(16'h0002);
        fire(12'h0A5);
        rd_chk("snap_status1", 3'd2, 32'h1);
        check_eq("snap_fifo_ne", 32'(FIFO_NE), 32'd1);
        rd_chk("snap_tag", 3'd4, 32'h0A5);
        rd_chk("snap_data", 3'd3, 32'h2);
        rd_chk("snap_status0", 3'd2, 32'h0001_0000);
        rd_chk("snap_tag_empty", 3'd4, FILL);
        rd_chk("unmapped6", 3'd6, FILL);

        // Overflow: five triggers into a four-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            reg_wr(3'd0, 32'h0);
            nim_pulse(16'(i));
            fire(12'(i * 16));
        end
        rd_chk("ovf_status", 3'd2, 32'h0006_0004);
        for (int i = 1; i <= 4; i++) begin
            rd_chk("ovf_tag", 3'd4, 32'(i * 16));
            rd_chk("ovf_pop", 3'd3, 32'(i));
        end
        rd_chk("ovf_pop_empty", 3'd3, FILL);
        rd_chk("ovf_sticky", 3'd2, 32'h0005_0000);
        reg_wr(3'd2, 32'h0);
        rd_chk("ovf_cleared", 3'd2, 32'h0001_0000);

        // Push and pop in the same cycle while full
        for (int i = 1; i <= 4; i++) begin
            reg_wr(3'd0, 32'h0);
            nim_pulse(16'(i));
            fire(12'(i));
        end
        fire_with_strobe(12'h055, 1'b0, 3'd3, d);
        check_eq("pp_pop_head", d, 32'h1);
        rd_chk("pp_status", 3'd2, 32'h0002_0004);
        for (int i = 2; i <= 4; i++) rd_chk("pp_pop", 3'd3, 32'(i));
        rd_chk("pp_new_tag", 3'd4, 32'h055);
        rd_chk("pp_new_data", 3'd3, 32'h4);
        rd_chk("pp_status_end", 3'd2, 32'h0001_0000);

        // Flush coinciding with a push keeps only the new entry
        fire(12'h001);
        fire(12'h002);
        reg_wr(3'd0, 32'h0);
        nim_pulse(16'h0009);
        fire_with_strobe(12'h03C, 1'b1, 3'd5, d);
        rd_chk("flush_status", 3'd2, 32'h1);
        rd_chk("flush_tag", 3'd4, 32'h03C);
        rd_chk("flush_data", 3'd3, 32'h9);

        // Auto-clear with an input rising in the trigger cycle
        reg_wr(3'd1, 32'h3);
        reg_wr(3'd0, 32'h0);
        nim_pulse(16'h0010);
        rd_chk("ac_pre", 3'd0, 32'h10);
        @(negedge SYSCLK);
        ENC    = 12'h077;
        TRIG   = 1'b1;
        NIM_IN = 16'h0020;
        repeat (5) @(negedge SYSCLK);
        TRIG   = 1'b0;
        NIM_IN = '0;
        repeat (5) @(negedge SYSCLK);
        rd_chk("ac_latch", 3'd0, 32'h20);
        rd_chk("ac_tag", 3'd4, 32'h077);
        rd_chk("ac_data", 3'd3, 32'h10);
        reg_wr(3'd1, 32'h0);
        reg_wr(3'd0, 32'h0);

        // Write and read strobes together: write applies, read dropped
        @(negedge SYSCLK);
        ADDR   = 3'd1;
        WDATA  = 32'hFFFF_FFF2;
        WR_STB = 1'b1;
        RD_STB = 1'b1;
        @(negedge SYSCLK);
        WR_STB = 1'b0;
        RD_STB = 1'b0;
        check_eq("wr_rd_rvalid", 32'(RVALID), 32'd0);
        rd_chk("wr_rd_ctrl", 3'd1, 32'h2);
        reg_wr(3'd1, 32'h0);

        // Reset in the middle of operation
        for (int i = 0; i < 3; i++) fire(12'(i + 7));
        nim_pulse(16'h0100);
        rd_chk("mid_status", 3'd2, 32'h3);
        @(negedge SYSCLK);
        ADDR   = 3'd0;
        RD_STB = 1'b1;
        @(posedge SYSCLK);
        #1;
        check_eq("mid_rvalid_pre", 32'(RVALID), 32'd1);
        check_eq("mid_latch_pre", RDATA, 32'h100);
        RSTB   = 1'b0;
        RD_STB = 1'b0;
        #1;
        check_eq("mid_rst_rvalid", 32'(RVALID), 32'd0);
        check_eq("mid_rst_rdata", RDATA, 32'd0);
        check_eq("mid_rst_fifo_ne", 32'(FIFO_NE), 32'd0);
        repeat (2) @(negedge SYSCLK);
        RSTB = 1'b1;
        rd_chk("mid_status_after", 3'd2, 32'h0001_0000);
        rd_chk("mid_latch_after", 3'd0, 32'h0);

        // Random transactions against the model
        m_reset();
        for (int n = 0; n < 220; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: begin
                    p = 16'($urandom) & 16'($urandom);
                    nim_pulse(p);
                    m_latch = m_latch | p;
                end
                3, 4: begin
                    e = 12'($urandom);
                    fire(e);
                    m_fire(e);
                end
                5: begin
                    rd_chk("rnd_pop", 3'd3, (m_q.size() != 0) ? 32'(m_q[0][15:0]) : FILL);
                    if (m_q.size() != 0) void'(m_q.pop_front());
                end
                6: rd_chk("rnd_tag", 3'd4, (m_q.size() != 0) ? 32'(m_q[0][27:16]) : FILL);
                7: rd_chk("rnd_status", 3'd2, m_status());
                8: begin
                    rd_chk("rnd_latch", 3'd0, 32'(m_latch));
                    if ($urandom_range(0, 2) == 0) begin
                        reg_wr(3'd0, $urandom);
                        m_latch = '0;
                    end
                end
                default: begin
                    case ($urandom_range(0, 4))
                        0: begin
                            c = 2'($urandom);
                            reg_wr(3'd1, {30'($urandom), c});
                            m_ctrl = c;
                        end
                        1: begin
                            reg_wr(3'd2, $urandom);
                            m_ovf = 1'b0;
                        end
                        2: begin
                            reg_wr(3'd5, $urandom);
                            m_q.delete();
                        end
                        3: rd_chk("rnd_ctrl", 3'd1, 32'(m_ctrl));
                        default: begin
                            reg_wr(3'd7, $urandom);
                            rd_chk("rnd_unmapped", 3'(6 + $urandom_range(0, 1)), FILL);
                        end
                    endcase
                end
            endcase
            @(negedge SYSCLK);
            check_eq("rnd_fifo_ne", 32'(FIFO_NE), (m_q.size() != 0) ? 32'd1 : 32'd0);
        end
        rd_chk("rnd_final_status", 3'd2, m_status());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
